// File: rtl/iter_rect.sv
// Rectangle pixel iterator. Walks a filled or outline-only axis-aligned
//   rectangle in raster order, one pixel per cycle, clipped to the coordinate space.
// Latency: the first pixel is presented the cycle after start is accepted.
//   The last pixel is followed one cycle later by a single-cycle done pulse.
// Backpressure: with oe low, the current pixel, the position and the state hold.
//   abort overrides oe and returns the block to idle without a done pulse.
// Ports: clk/rst_n     clock and asynchronous active-low reset
//        start/abort   launch (accepted only when idle) / cancel the current draw
//        oe            downstream enable; the current pixel is consumed when high
//        mode,x0,y0,w,h geometry, sampled only on the accepting start cycle
//        x,y,drawing   current pixel and its qualifier (drawing = in DRAW and oe)
//        busy,done     draw in progress / one-cycle completion pulse
module iter_rect #(
  parameter int unsigned CORDW = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             oe,
  input  logic             abort,
  input  logic             mode,
  input  logic [CORDW-1:0] x0,
  input  logic [CORDW-1:0] y0,
  input  logic [CORDW-1:0] w,
  input  logic [CORDW-1:0] h,
  output logic [CORDW-1:0] x,
  output logic [CORDW-1:0] y,
  output logic             drawing,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, DRAW = 1'b1} state_t;

  localparam logic [CORDW-1:0] ONE = CORDW'(1);

  state_t state, state_next;

  // Latched geometry: start corner, clipped end corner and outline flag.
  logic [CORDW-1:0] xs, ys, xe, ye;
  logic             outline;

  // Endpoints carry one extra bit so a sum past the coordinate space is
  // caught and clamped instead of wrapping back to zero.
  logic [CORDW:0]   x1_sum, y1_sum;
  logic [CORDW-1:0] x1_clip, y1_clip;

  assign x1_sum  = {1'b0, x0} + {1'b0, w};
  assign y1_sum  = {1'b0, y0} + {1'b0, h};
  assign x1_clip = x1_sum[CORDW] ? '1 : x1_sum[CORDW-1:0];
  assign y1_clip = y1_sum[CORDW] ? '1 : y1_sum[CORDW-1:0];

  logic accept, advance, last_px, interior_row;

  assign accept       = (state == IDLE) && start;
  assign advance      = (state == DRAW) && oe && !abort;
  assign last_px      = (x == xe) && (y == ye);
  assign interior_row = (y != ys) && (y != ye);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; abort takes priority over pixel consumption.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = DRAW;
      DRAW: begin
        if (abort)                state_next = IDLE;
        else if (oe && last_px)   state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy    = (state == DRAW);
    drawing = (state == DRAW) && oe;
  end

  // Position walker, geometry latch and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      y       <= '0;
      xs      <= '0;
      ys      <= '0;
      xe      <= '0;
      ye      <= '0;
      outline <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= advance && last_px;
      if (accept) begin
        x       <= x0;
        y       <= y0;
        xs      <= x0;
        ys      <= y0;
        xe      <= x1_clip;
        ye      <= y1_clip;
        outline <= mode;
      end else if (advance) begin
        if (x != xe) begin
          // Interior outline rows only have the two edge pixels.
          if (outline && interior_row) x <= xe;
          else                         x <= x + ONE;
        end else if (y != ye) begin
          x <= xs;
          y <= y + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_iter_rect.sv
module tb_iter_rect;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, oe, abort, mode;
  logic [9:0] x0, y0, w, h;
  logic [9:0] x, y;
  logic       drawing, busy, done;

  int checks = 0;
  int errors = 0;

  iter_rect #(.CORDW(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .oe(oe), .abort(abort),
    .mode(mode), .x0(x0), .y0(y0), .w(w), .h(h),
    .x(x), .y(y), .drawing(drawing), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic [9:0] vx0, vy0, vw, vh;
    int         npix;     // expected pixel count, worked out by hand
    int         oe_mode;  // 0 = always on, 1 = pattern 1,0,0,1, 2 = random
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge. Drives a start, then consumes the whole rectangle
  // while scrambling start and geometry, and compares each emitted pixel
  // with a list built directly from the rectangle definition. Returns at the
  // negedge where done is expected high.
  task automatic run_rect(input logic m, input logic [9:0] ax0, input logic [9:0] ay0,
                          input logic [9:0] aw, input logic [9:0] ah,
                          input int oe_mode, input bit abort_with_start,
                          input int exp_npix);
    int qx[$];
    int qy[$];
    int ex, ey, npix, cyc;
    bit finished;
    ex = int'(ax0) + int'(aw);
    ey = int'(ay0) + int'(ah);
    if (ex > 1023) ex = 1023;
    if (ey > 1023) ey = 1023;
    for (int yy = int'(ay0); yy <= ey; yy++)
      for (int xx = int'(ax0); xx <= ex; xx++)
        if (!m || yy == int'(ay0) || yy == ey || xx == int'(ax0) || xx == ex) begin
          qx.push_back(xx);
          qy.push_back(yy);
        end

    start = 1'b1; mode = m; x0 = ax0; y0 = ay0; w = aw; h = ah;
    oe = 1'b1; abort = abort_with_start;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("done_after_start", int'(done), 0);

    npix = 0; cyc = 0; finished = 0;
    while (cyc < 4000 && !finished) begin
      case (oe_mode)
        0:       oe = 1'b1;
        1:       oe = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: oe = 1'($urandom_range(0, 1));
      endcase
      // Garbage on the request inputs while busy must be ignored.
      start = 1'($urandom_range(0, 1));
      mode  = 1'($urandom_range(0, 1));
      x0 = 10'($urandom); y0 = 10'($urandom); w = 10'($urandom); h = 10'($urandom);
      #1;
      chk("drawing_eq_oe", int'(drawing), int'(oe));
      if (drawing) begin
        if (qx.size() == 0) begin
          chk("extra_pixel", npix, qx.size());
        end else begin
          chk("pix_x", int'(x), qx[0]);
          chk("pix_y", int'(y), qy[0]);
          void'(qx.pop_front());
          void'(qy.pop_front());
        end
        npix++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (!busy) finished = 1;
      else       chk("done_low_while_busy", int'(done), 0);
    end
    start = 1'b0;
    if (!finished) chk("draw_timeout", 0, 1);
    chk("done_pulse", int'(done), 1);
    chk("pixels_left", qx.size(), 0);
    if (exp_npix >= 0) chk("pixel_count", npix, exp_npix);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b0, 10'd5,    10'd7,    10'd2,  10'd1,  6,   0};
    vecs[1]  = '{1'b1, 10'd0,    10'd0,    10'd3,  10'd3,  12,  0};
    vecs[2]  = '{1'b0, 10'd1020, 10'd0,    10'd10, 10'd0,  4,   0};
    vecs[3]  = '{1'b0, 10'd50,   10'd60,   10'd1,  10'd1,  4,   1};
    vecs[4]  = '{1'b0, 10'd9,    10'd9,    10'd0,  10'd0,  1,   0};
    vecs[5]  = '{1'b0, 10'd3,    10'd4,    10'd0,  10'd5,  6,   0};
    vecs[6]  = '{1'b0, 10'd3,    10'd4,    10'd6,  10'd0,  7,   0};
    vecs[7]  = '{1'b1, 10'd10,   10'd10,   10'd4,  10'd1,  10,  2};
    vecs[8]  = '{1'b1, 10'd10,   10'd10,   10'd0,  10'd4,  5,   2};
    vecs[9]  = '{1'b1, 10'd2,    10'd3,    10'd4,  10'd2,  12,  2};
    vecs[10] = '{1'b1, 10'd1023, 10'd1023, 10'd5,  10'd5,  1,   0};
    vecs[11] = '{1'b0, 10'd1000, 10'd1018, 10'd30, 10'd10, 144, 2};

    rst_n = 1'b0; start = 1'b0; oe = 1'b1; abort = 1'b0; mode = 1'b0;
    x0 = 10'd77; y0 = 10'd88; w = 10'd3; h = 10'd3;
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_drawing", int'(drawing), 0);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, back to back: each start lands in the done cycle of the previous one.
    foreach (vecs[i])
      run_rect(vecs[i].m, vecs[i].vx0, vecs[i].vy0, vecs[i].vw, vecs[i].vh,
               vecs[i].oe_mode, 1'b0, vecs[i].npix);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("idle_after_done", int'(busy), 0);

    // abort in idle does nothing; abort together with start lets start win
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle_busy", int'(busy), 0);
    chk("abort_idle_done", int'(done), 0);
    run_rect(1'b0, 10'd30, 10'd40, 10'd1, 10'd2, 0, 1'b1, 6);
    @(negedge clk);

    // abort at the third pixel of a filled 4x4
    start = 1'b1; mode = 1'b0; x0 = 10'd10; y0 = 10'd20; w = 10'd3; h = 10'd3; oe = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ab_p1_x", int'(x), 10);
    @(negedge clk);
    chk("ab_p2_x", int'(x), 11);
    @(negedge clk);
    chk("ab_p3_x", int'(x), 12);
    chk("ab_p3_y", int'(y), 20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", int'(busy), 0);
    chk("ab_done", int'(done), 0);
    chk("ab_drawing", int'(drawing), 0);
    @(negedge clk);
    chk("ab_done_later", int'(done), 0);
    run_rect(1'b0, 10'd3, 10'd4, 10'd1, 10'd1, 0, 1'b0, 4);
    @(negedge clk);

    // asynchronous reset between edges in the middle of a draw
    start = 1'b1; mode = 1'b0; x0 = 10'd100; y0 = 10'd200; w = 10'd3; h = 10'd3; oe = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_drawing", int'(drawing), 0);
    chk("mid_rst_x", int'(x), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", int'(done), 0);
    run_rect(1'b1, 10'd7, 10'd8, 10'd3, 10'd3, 2, 1'b0, 12);

    // randomized rectangles against the pixel-list model
    for (int n = 0; n < 30; n++) begin
      logic [9:0] rx, ry;
      rx = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1005, 1023)) : 10'($urandom);
      ry = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1005, 1023)) : 10'($urandom);
      run_rect(1'($urandom_range(0, 1)), rx, ry, 10'($urandom_range(0, 15)),
               10'($urandom_range(0, 15)), 2, 1'b0, -1);
    end
    @(negedge clk);
    chk("final_idle", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iter_rect.md
Name: iter_rect

Overview:
Parametrised rectangle pixel iterator for the render pipeline, the successor to the square iterator. It walks every pixel of an axis-aligned rectangle, either filled or outline-only, with independent width and height. Pixels are emitted one per cycle under the downstream output-enable. The block latches its geometry at start, clips to the coordinate space, and supports abort mid-draw.

Parameters:
CORDW, 10, unsigned coordinate width in bits (x, y, w, h).

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new rectangle; accepted only in IDLE
oe  input  1  output enable; the current pixel advances only when high
abort  input  1  terminate the current draw; no done pulse
mode  input  1  0 = filled, 1 = outline only; latched at start
x0  input  CORDW  top-left x; latched at start
y0  input  CORDW  top-left y; latched at start
w  input  CORDW  width minus 1 (inclusive span x0..x0+w); latched at start
h  input  CORDW  height minus 1 (inclusive span y0..y0+h); latched at start
x  output  CORDW  current pixel x
y  output  CORDW  current pixel y
drawing  output  1  (x,y) is a valid pixel this cycle; equals (state==DRAW && oe)
busy  output  1  request in progress
done  output  1  one-cycle pulse after the last pixel is consumed

Behaviour:
- Reset (async, rst_n=0): state IDLE; x=0, y=0, busy=0, done=0; drawing=0; latched geometry cleared. Reset mid-draw aborts immediately with no done pulse.
- States:
  - IDLE -> DRAW on start. Next cycle: x=x0, y=y0, busy=1, done=0.
  - DRAW -> IDLE after the last pixel is consumed, or on abort.
- Latency: the first pixel is valid the cycle after start, provided oe is high.
- Endpoints: x1 = x0+w and y1 = y0+h are computed in CORDW+1 bits at start.
  - On overflow, x1 or y1 is clamped to 2^CORDW-1, so the rectangle is clipped and never wraps.
- Advance (DRAW with oe=1, abort=0):
  - If x != x1: x increments, except in outline mode on an interior row (y != y0 and y != y1), where x jumps from x0 directly to x1.
  - If x == x1 and y != y1: x returns to x0 and y increments.
  - If x == x1 and y == y1 (last pixel): next cycle state is IDLE, busy=0, done=1.
- oe=0 in DRAW: x, y and state are held; drawing=0.
- done: high for exactly one cycle, then cleared in IDLE.
- start handling:
  - start while busy is ignored.
  - start in the cycle done is high is accepted, since the state is IDLE.
  - Inputs are sampled only on the accepting cycle; changes during DRAW have no effect.
- abort: has priority over oe. Next cycle: IDLE, busy=0, done=0. abort in IDLE has no effect; abort and start together in IDLE means start wins.
- Degenerate geometry:
  - w=0 gives a single column; h=0 gives a single row; both zero gives one pixel.
  - Outline with w=0 or h<=1 emits the same pixel set as filled.
- Pixel count:
  - Filled: (w+1)(h+1), after clamping.
  - Outline: 2(w+1)+2(h-1) when w>=1 and h>=1.
- Ordering: raster order, row-major, top to bottom, left to right. Every pixel is emitted exactly once.

Test Plan:
- Filled 3x2 (x0=5,y0=7,w=2,h=1, oe=1) -> drawing 6 cycles: (5,7),(6,7),(7,7),(5,8),(6,8),(7,8); busy drops and done pulses 1 cycle the cycle after (7,8).
- Outline 4x4 (x0=0,y0=0,w=3,h=3,mode=1) -> 12 pixels; rows y=1,2 emit only x=0 then x=3; done after (3,3).
- oe toggled 1,0,0,1,... on a filled 2x2 -> x/y hold while oe=0; exactly 4 drawing cycles total, correct order.
- Clip: CORDW=10, x0=1020, w=10, y0=0, h=0 -> pixels x=1020..1023 only (4 cycles), no wrap to 0; done asserted.
- abort at the 3rd pixel of filled 4x4 -> next cycle busy=0, done never pulses; a new start 1 cycle later draws correctly from its own x0,y0.
- rst_n pulsed low mid-draw (asynchronously, between edges) -> busy, done, drawing are 0 immediately; start issued after release is ignored while busy and accepted only in IDLE.
